// File: rtl/ninjakun_hiscore_ctrl_pkg.sv
// Shared definitions for the Ninjakun hiscore controller.
//   hs_state_e : top-level sequencer states (boot wait, probe, restore, idle, dump)
//   hs_phase_e : guard phases wrapped around every work-RAM transfer
//   HS_RAM_SEL : address bits [15:13] that the game top level decodes as hs_cs_ram
package ninjakun_hiscore_ctrl_pkg;

  typedef enum logic [2:0] {
    StWaitBoot,
    StProbe,
    StRestore,
    StRun,
    StDump
  } hs_state_e;

  // PhLead: pause/busy only; PhGrant: port granted, no access yet; PhXfer: accesses;
  // PhTail: port still granted after the last access; PhRelease: pause/busy only.
  typedef enum logic [2:0] {
    PhOff,
    PhLead,
    PhGrant,
    PhXfer,
    PhTail,
    PhRelease
  } hs_phase_e;

  localparam logic [2:0] HS_RAM_SEL = 3'b111;

  // Buffer index width; a one-entry table still needs a one-bit address.
  function automatic int unsigned buf_aw(input int unsigned len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/ninjakun_hiscore_ctrl_hs_buf.sv
// Hiscore table buffer: HS_LEN x 8 dual-port RAM, both ports with one-cycle read latency.
//   clk                          : system clock
//   a_we/a_addr/a_wdata/a_rdata  : host loader port
//   b_we/b_addr/b_wdata/b_rdata  : sequencer port (read for restore, write for dump)
// Contents are deliberately not reset so a loaded table survives a game reset.
module ninjakun_hs_buf #(
  parameter int unsigned HS_LEN = 32,
  parameter int unsigned AW     = 5
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  output logic [7:0]    a_rdata,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_wdata,
  output logic [7:0]    b_rdata
);

  logic [7:0] mem [HS_LEN];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
    a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/ninjakun_hiscore_ctrl.sv
// Hiscore port initiator for the Ninjakun core.
// Keeps a byte copy of the hiscore table, waits for the game to write its RAM defaults,
// restores the copy into work RAM, and on request dumps work RAM back into the copy.
// Every transfer is wrapped in a guard: pause/busy first, then the port grant, then
// the accesses, and the same steps undone in reverse order.
//
// Ports:
//   CLK24M, RESET        : clock, asynchronous active-high reset
//   VBLK                 : vertical blank (rising edge = one frame)
//   PAUSE_IN             : OSD pause level (autosave trigger when enabled)
//   DUMP_REQ             : one-cycle request to copy work RAM into the buffer
//   HOST_WR/ADR/DIN/DOUT : loader access to the buffer (DOUT one cycle after ADR)
//   BUSY, PAUSE_REQ      : high for the whole guarded transfer
//   DUMP_DONE            : one-cycle pulse when a dump completes
//   hs_*                 : hiscore port into game work RAM
//
// Build option NINJAKUN_HS_AUTOSAVE_EN: a PAUSE_IN rising edge also requests a dump.
module ninjakun_hiscore_ctrl
  import ninjakun_hiscore_ctrl_pkg::*;
#(
  parameter logic [15:0] HS_BASE    = 16'hE000,
  parameter int unsigned HS_LEN     = 32,
  parameter logic [15:0] CHK_ADDR   = 16'hE000,
  parameter logic [7:0]  CHK_VAL    = 8'h00,
  parameter int unsigned START_WAIT = 60,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic        CLK24M,
  input  logic        RESET,
  input  logic        VBLK,
  input  logic        PAUSE_IN,
  input  logic        DUMP_REQ,
  input  logic        HOST_WR,
  input  logic [7:0]  HOST_ADR,
  input  logic [7:0]  HOST_DIN,
  output logic [7:0]  HOST_DOUT,
  output logic        BUSY,
  output logic        DUMP_DONE,
  output logic        PAUSE_REQ,
  output logic [15:0] hs_address,
  output logic [7:0]  hs_data_in,
  input  logic [7:0]  hs_data_out,
  output logic        hs_write,
  output logic        hs_access
);

  localparam int unsigned AW         = buf_aw(HS_LEN);
  localparam logic [7:0]  LastIdx    = 8'(HS_LEN - 1);
  localparam logic [7:0]  LastLat    = 8'(RD_LAT);
  localparam logic [15:0] BootFrames = 16'(START_WAIT);
  localparam logic [8:0]  TableLen   = 9'(HS_LEN);

  hs_state_e   state_q, state_d;
  hs_phase_e   phase_q, phase_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  lat_q, lat_d;
  logic [15:0] frame_q, frame_d;
  logic        loaded_q, loaded_d;
  logic        pend_q, pend_d;
  logic        chk_ok_q, chk_ok_d;
  logic        vblk_q;

  logic          vblk_rise, host_we, rd_last, idx_last, dump_trig, auto_trig;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [7:0]    b_rdata;

  assign vblk_rise = VBLK & ~vblk_q;
  assign host_we   = HOST_WR & ({1'b0, HOST_ADR} < TableLen) & ~BUSY;
  assign rd_last   = (lat_q == LastLat);
  assign idx_last  = (idx_q == LastIdx);
  assign dump_trig = DUMP_REQ | auto_trig;

`ifdef NINJAKUN_HS_AUTOSAVE_EN
  logic pause_q;
  always_ff @(posedge CLK24M or posedge RESET) begin
    if (RESET) pause_q <= 1'b0;
    else       pause_q <= PAUSE_IN;
  end
  assign auto_trig = PAUSE_IN & ~pause_q &
                     ((state_q == StRun) | (loaded_q & (state_q inside {StRestore, StDump})));
`else
  logic unused_pause;
  assign unused_pause = PAUSE_IN;
  assign auto_trig    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    lat_d    = lat_q;
    frame_d  = frame_q;
    chk_ok_d = chk_ok_q;
    loaded_d = loaded_q | host_we;
    // Requests outside RUN are remembered; inside RUN they start the dump directly.
    pend_d   = pend_q | (dump_trig & (state_q != StRun));

    unique case (phase_q)
      PhOff:     ;
      PhLead:    phase_d = PhGrant;
      PhGrant: begin
        phase_d = PhXfer;
        idx_d   = '0;
        lat_d   = '0;
      end
      PhXfer: begin
        unique case (state_q)
          StRestore: begin
            idx_d = idx_q + 8'd1;
            if (idx_last) phase_d = PhTail;
          end
          StProbe: begin
            lat_d = lat_q + 8'd1;
            if (rd_last) begin
              chk_ok_d = (hs_data_out == CHK_VAL);
              phase_d  = PhTail;
            end
          end
          StDump: begin
            lat_d = lat_q + 8'd1;
            if (rd_last) begin
              lat_d = '0;
              idx_d = idx_q + 8'd1;
              if (idx_last) phase_d = PhTail;
            end
          end
          default: ;
        endcase
      end
      PhTail:    phase_d = PhRelease;
      PhRelease: phase_d = PhOff;
      default:   phase_d = PhOff;
    endcase

    unique case (state_q)
      StWaitBoot: begin
        if (vblk_rise) begin
          frame_d = frame_q + 16'd1;
          if (frame_d == BootFrames) begin
            state_d = StProbe;
            phase_d = PhLead;
          end
        end
      end
      StProbe: begin
        if (phase_q == PhRelease) begin
          if (chk_ok_q) state_d = loaded_q ? StRestore : StRun;
        end else if (phase_q == PhOff && vblk_rise) begin
          phase_d = PhLead;
        end
      end
      StRestore: begin
        if (phase_q == PhOff)          phase_d = PhLead;
        else if (phase_q == PhRelease) state_d = StRun;
      end
      StRun: begin
        if (pend_q | dump_trig) state_d = StDump;
      end
      StDump: begin
        if (phase_q == PhOff) begin
          phase_d = PhLead;
        end else if (phase_q == PhRelease) begin
          state_d = StRun;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = StWaitBoot;
        phase_d = PhOff;
      end
    endcase
  end

  always_ff @(posedge CLK24M or posedge RESET) begin
    if (RESET) begin
      state_q  <= StWaitBoot;
      phase_q  <= PhOff;
      idx_q    <= '0;
      lat_q    <= '0;
      frame_q  <= '0;
      loaded_q <= 1'b0;
      pend_q   <= 1'b0;
      chk_ok_q <= 1'b0;
      vblk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      lat_q    <= lat_d;
      frame_q  <= frame_d;
      loaded_q <= loaded_d;
      pend_q   <= pend_d;
      chk_ok_q <= chk_ok_d;
      vblk_q   <= VBLK;
    end
  end

  // Restore reads one entry ahead (next index) so the byte is ready on its write cycle.
  assign b_addr = (state_q == StDump) ? idx_q[AW-1:0] : idx_d[AW-1:0];
  assign b_we   = (state_q == StDump) & (phase_q == PhXfer) & rd_last;

  ninjakun_hs_buf #(
    .HS_LEN (HS_LEN),
    .AW     (AW)
  ) u_buf (
    .clk     (CLK24M),
    .a_we    (host_we),
    .a_addr  (HOST_ADR[AW-1:0]),
    .a_wdata (HOST_DIN),
    .a_rdata (HOST_DOUT),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_wdata (hs_data_out),
    .b_rdata (b_rdata)
  );

  // Outputs decode straight from async-reset flops so RESET drops them immediately.
  always_comb begin
    hs_address = '0;
    if (phase_q == PhXfer) begin
      hs_address = (state_q == StProbe) ? CHK_ADDR : HS_BASE + {8'h00, idx_q};
    end
  end

  assign hs_write   = (state_q == StRestore) & (phase_q == PhXfer);
  assign hs_data_in = hs_write ? b_rdata : 8'h00;
  assign hs_access  = phase_q inside {PhGrant, PhXfer, PhTail};
  assign BUSY       = (phase_q != PhOff);
  assign PAUSE_REQ  = BUSY;
  assign DUMP_DONE  = (state_q == StDump) & (phase_q == PhRelease);

endmodule

// File: tb/tb_ninjakun_hiscore_ctrl.sv
// Self-checking bench for ninjakun_hiscore_ctrl: work-RAM model with RD_LAT read pipeline,
// scoreboard queues for expected RAM writes and hs_access burst lengths.
module tb_ninjakun_hiscore_ctrl;

  localparam int unsigned HS_LEN     = 32;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned START_WAIT = 60;
  localparam int RunProbe   = RD_LAT + 3;
  localparam int RunRestore = HS_LEN + 2;
  localparam int RunDump    = HS_LEN * (RD_LAT + 1) + 2;

  logic        clk = 1'b0;
  logic        RESET = 1'b1, VBLK = 1'b0, PAUSE_IN = 1'b0, DUMP_REQ = 1'b0, HOST_WR = 1'b0;
  logic [7:0]  HOST_ADR = '0, HOST_DIN = '0;
  logic [7:0]  HOST_DOUT;
  logic        BUSY, DUMP_DONE, PAUSE_REQ, hs_write, hs_access;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in, hs_data_out;

  always #5 clk = ~clk;

  ninjakun_hiscore_ctrl dut (
    .CLK24M      (clk),
    .RESET       (RESET),
    .VBLK        (VBLK),
    .PAUSE_IN    (PAUSE_IN),
    .DUMP_REQ    (DUMP_REQ),
    .HOST_WR     (HOST_WR),
    .HOST_ADR    (HOST_ADR),
    .HOST_DIN    (HOST_DIN),
    .HOST_DOUT   (HOST_DOUT),
    .BUSY        (BUSY),
    .DUMP_DONE   (DUMP_DONE),
    .PAUSE_REQ   (PAUSE_REQ),
    .hs_address  (hs_address),
    .hs_data_in  (hs_data_in),
    .hs_data_out (hs_data_out),
    .hs_write    (hs_write),
    .hs_access   (hs_access)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Work RAM model
  logic [7:0]  ram [65536];
  logic [7:0]  rd_p1;
  logic        rq_en = 1'b0;
  logic [15:0] rq_addr = '0;
  logic [7:0]  rq_data = '0;

  always @(posedge clk) begin
    if (rq_en) ram[rq_addr] <= rq_data;
    else if (hs_access && hs_write) ram[hs_address] <= hs_data_in;
    rd_p1       <= ram[hs_address];
    hs_data_out <= rd_p1;
  end

  // Scoreboards
  logic [23:0] exp_wr [$];
  int          exp_run [$];
  int wr_total = 0, wr_run = 0, acc_len = 0, last_acc = 0, busy_len = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (hs_write) begin
      wr_total <= wr_total + 1;
      wr_run   <= wr_run + 1;
      check_eq("wr_expected", 32'(exp_wr.size() > 0), 1);
      if (exp_wr.size() > 0) begin
        check_eq("wr_addr", 32'(hs_address), 32'(exp_wr[0][23:8]));
        check_eq("wr_data", 32'(hs_data_in), 32'(exp_wr[0][7:0]));
        exp_wr.delete(0);
      end
    end else if (wr_run != 0) begin
      if (!RESET) check_eq("wr_burst_len", wr_run, HS_LEN);
      wr_run <= 0;
    end
    if (hs_access) begin
      acc_len <= acc_len + 1;
      check_eq("guard_pause_busy", 32'(PAUSE_REQ && BUSY), 1);
    end else if (acc_len != 0) begin
      check_eq("acc_expected", 32'(exp_run.size() > 0), 1);
      if (exp_run.size() > 0) begin
        check_eq("acc_run_len", acc_len, exp_run[0]);
        exp_run.delete(0);
      end
      last_acc <= acc_len;
      acc_len  <= 0;
    end
    if (BUSY) busy_len <= busy_len + 1;
    else if (busy_len != 0) begin
      if (!RESET) check_eq("busy_run_len", busy_len, last_acc + 2);
      busy_len <= 0;
    end
    if (DUMP_DONE) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      VBLK = 1'b1;
      idle(2);
      VBLK = 1'b0;
      idle(40);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    idle(3);
    RESET = 1'b0;
    step();
  endtask

  task automatic ram_set(input logic [15:0] a, input logic [7:0] d);
    rq_addr = a;
    rq_data = d;
    rq_en   = 1'b1;
    step();
    rq_en   = 1'b0;
  endtask

  task automatic host_write(input int a, input logic [7:0] d);
    HOST_ADR = 8'(a);
    HOST_DIN = d;
    HOST_WR  = 1'b1;
    step();
    HOST_WR  = 1'b0;
  endtask

  task automatic host_read(input int a, output logic [7:0] d);
    HOST_ADR = 8'(a);
    step();
    d = HOST_DOUT;
  endtask

  // Loads base+i into the buffer; the first n_exp bytes are expected to be restored.
  task automatic load_buf(input logic [7:0] base, input int n_exp);
    for (int i = 0; i < HS_LEN; i++) begin
      host_write(i, 8'(base + i));
      if (i < n_exp) exp_wr.push_back({16'(16'hE000 + i), 8'(base + i)});
    end
  endtask

  task automatic dump_pulse();
    DUMP_REQ = 1'b1;
    step();
    DUMP_REQ = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int base, done0;

    // Reset values
    idle(3);
    check_eq("rst_hs_access", hs_access, 0);
    check_eq("rst_hs_write", hs_write, 0);
    check_eq("rst_hs_address", hs_address, 0);
    check_eq("rst_hs_data_in", hs_data_in, 0);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_pause_req", PAUSE_REQ, 0);
    check_eq("rst_dump_done", DUMP_DONE, 0);
    RESET = 1'b0;
    step();

    // 1: loaded buffer restored after the 60th VBLK edge
    ram_set(16'hE000, 8'h00);
    load_buf(8'hA0, HS_LEN);
    frames(START_WAIT - 1);
    check_eq("t1_boot_idle", BUSY, 0);
    exp_run.push_back(RunProbe);
    exp_run.push_back(RunRestore);
    frames(1);
    idle(80);
    check_eq("t1_runs_left", exp_run.size(), 0);
    check_eq("t1_wr_left", exp_wr.size(), 0);
    check_eq("t1_busy_end", BUSY, 0);
    for (int i = 0; i < HS_LEN; i += 15)
      check_eq("t1_ram", ram[16'(16'hE000 + i)], 8'(8'hA0 + i));

    // 2: no load (out-of-range writes dropped) -> probe only, no restore
    do_reset();
    ram_set(16'hE000, 8'h00);
    host_write(32, 8'h11);
    host_write(200, 8'h22);
    base = wr_total;
    frames(START_WAIT - 1);
    check_eq("t2_boot_idle", BUSY, 0);
    exp_run.push_back(RunProbe);
    frames(1);
    idle(30);
    check_eq("t2_runs_left", exp_run.size(), 0);
    check_eq("t2_no_writes", wr_total - base, 0);
    check_eq("t2_busy_end", BUSY, 0);

    // 3: check value wrong for three frames, fourth probe passes
    do_reset();
    ram_set(16'hE000, 8'h55);
    load_buf(8'h10, HS_LEN);
    frames(START_WAIT - 1);
    check_eq("t3_boot_idle", BUSY, 0);
    for (int p = 0; p < 3; p++) begin
      exp_run.push_back(RunProbe);
      frames(1);
    end
    check_eq("t3_probe_runs", exp_run.size(), 0);
    check_eq("t3_no_restore_yet", exp_wr.size(), HS_LEN);
    ram_set(16'hE000, 8'h00);
    exp_run.push_back(RunProbe);
    exp_run.push_back(RunRestore);
    frames(1);
    idle(80);
    check_eq("t3_runs_left", exp_run.size(), 0);
    check_eq("t3_wr_left", exp_wr.size(), 0);

    // 4: dump from RUN
    for (int i = 0; i < HS_LEN; i++) ram_set(16'(16'hE000 + i), 8'(i * 3));
    done0 = done_cnt;
    exp_run.push_back(RunDump);
    dump_pulse();
    idle(150);
    check_eq("t4_done_pulses", done_cnt - done0, 1);
    check_eq("t4_runs_left", exp_run.size(), 0);
    for (int i = 0; i < HS_LEN; i++) begin
      host_read(i, d);
      check_eq("t4_dout", d, 8'(i * 3));
    end

    // 5: two dump requests during restore collapse; host writes while busy ignored
    do_reset();
    ram_set(16'hE000, 8'h00);
    load_buf(8'hC0, HS_LEN);
    frames(START_WAIT - 1);
    exp_run.push_back(RunProbe);
    exp_run.push_back(RunRestore);
    exp_run.push_back(RunDump);
    done0 = done_cnt;
    VBLK = 1'b1;
    for (int k = 0; k < 10 && !BUSY; k++) step();
    check_eq("t5_busy_rise", BUSY, 1);
    host_write(5, 8'hFF);
    for (int k = 0; k < 40 && !hs_write; k++) step();
    check_eq("t5_restore_start", hs_write, 1);
    dump_pulse();
    host_write(31, 8'hFF);
    dump_pulse();
    VBLK = 1'b0;
    idle(250);
    check_eq("t5_done_pulses", done_cnt - done0, 1);
    check_eq("t5_runs_left", exp_run.size(), 0);
    check_eq("t5_wr_left", exp_wr.size(), 0);
    host_read(0, d);
    check_eq("t5_dout0", d, 8'hC0);
    host_read(5, d);
    check_eq("t5_dout5", d, 8'hC5);
    host_read(31, d);
    check_eq("t5_dout31", d, 8'hDF);

    // 6: reset during restore byte 10
    do_reset();
    ram_set(16'hE000, 8'h00);
    load_buf(8'h50, 11);
    frames(START_WAIT - 1);
    exp_run.push_back(RunProbe);
    exp_run.push_back(1 + 11);
    base = wr_total;
    VBLK = 1'b1;
    for (int k = 0; k < 200 && (wr_total - base) < 11; k++) begin
      @(negedge clk);
      #1;
    end
    check_eq("t6_reached_byte10", wr_total - base, 11);
    RESET = 1'b1;
    #1;
    check_eq("t6_access_drop", hs_access, 0);
    check_eq("t6_write_drop", hs_write, 0);
    check_eq("t6_pause_drop", PAUSE_REQ, 0);
    VBLK = 1'b0;
    idle(3);
    RESET = 1'b0;
    step();
    check_eq("t6_runs_left", exp_run.size(), 0);
    check_eq("t6_wr_left", exp_wr.size(), 0);
    base = wr_total;
    frames(START_WAIT - 1);
    check_eq("t6_reboot_wait", BUSY, 0);
    exp_run.push_back(RunProbe);
    frames(1);
    idle(30);
    check_eq("t6_reprobe", exp_run.size(), 0);
    check_eq("t6_no_restore", wr_total - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
